// File: rtl/tile_dma_if.sv
// tile_dma_if: SDRAM read port and tile BRAM write port of the tile DMA.
interface tile_dma_if;
  logic [22:0] ram_addr;
  logic        ram_we;
  logic [31:0] ram_data;
  logic        ram_req;
  logic        ram_ack;
  logic        ram_valid;
  logic [31:0] ram_q;
  logic        tile_we;
  logic [13:0] tile_waddr;
  logic [15:0] tile_wdata;
  modport master (
    output ram_addr, ram_we, ram_data, ram_req, tile_we, tile_waddr, tile_wdata,
    input  ram_ack, ram_valid, ram_q
  );
  modport slave (
    input  ram_addr, ram_we, ram_data, ram_req, tile_we, tile_waddr, tile_wdata,
    output ram_ack, ram_valid, ram_q
  );
endinterface

// File: rtl/tile_dma.sv
// tile_dma: copies SDRAM words into the tile BRAM as two 16-bit writes each.
// Define VDP_DMA_ABORT_EN to add the abort input.
module tile_dma #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk_draw,
  input  logic        rst_draw_n,
  input  logic        start,
  input  logic [22:0] src_addr,
  input  logic [13:0] dst_addr,
  input  logic [12:0] len,
  output logic        busy,
  output logic        done,
`ifdef VDP_DMA_ABORT_EN
  input  logic        abort,
`endif
  tile_dma_if.master  bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  typedef enum logic [1:0] {IDLE, RUN, FLUSH, FINISH} state_t;
  state_t state, state_nx;
  logic [31:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] cnt, outst;
  logic [12:0] remain;
  logic [13:0] wa;
  logic [31:0] head;
  logic phase, active, kill, ack, push, wr, pop, issue;
  assign active = state == RUN || state == FLUSH;
`ifdef VDP_DMA_ABORT_EN
  logic aborting;
  assign kill = aborting || (abort && active);
`else
  assign kill = 1'b0;
`endif
  assign ack = bus.ram_req && bus.ram_ack;
  assign push = bus.ram_valid && active && !kill;
  assign wr = (cnt != '0 || push) && !kill;
  assign pop = wr && phase;
  // an empty FIFO forwards the returning word so its low half is written next cycle
  assign head = cnt != '0 ? mem[rd_ptr] : bus.ram_q;
  assign issue = state == RUN && !kill && (!bus.ram_req || ack) && !(ack && remain == 13'd1) &&
                 int'(outst) + int'(ack) + int'(cnt) + int'(bus.ram_valid) < FIFO_DEPTH;
  assign bus.ram_we = 1'b0;
  assign bus.ram_data = '0;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = len == '0 ? FINISH : RUN;
      RUN:     if (kill || (ack && remain == 13'd1)) state_nx = FLUSH;
      FLUSH:   if (outst == '0 && cnt == '0 && !bus.ram_req) state_nx = FINISH;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk_draw)
    if (push) mem[wr_ptr] <= bus.ram_q;
  always_ff @(posedge clk_draw or negedge rst_draw_n)
    if (!rst_draw_n) begin
      state          <= IDLE;
      busy           <= 1'b0;
      done           <= 1'b0;
      outst          <= '0;
      cnt            <= '0;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      phase          <= 1'b0;
      remain         <= '0;
      wa             <= '0;
      bus.ram_req    <= 1'b0;
      bus.ram_addr   <= '0;
      bus.tile_we    <= 1'b0;
      bus.tile_waddr <= '0;
      bus.tile_wdata <= '0;
    end else begin
      state       <= state_nx;
      // a zero-length launch still shows busy for its single done cycle
      busy        <= state_nx == RUN || state_nx == FLUSH || (state == IDLE && state_nx == FINISH);
      done        <= state_nx == FINISH;
      outst       <= outst + (AW+1)'(ack) - (AW+1)'(bus.ram_valid && active);
      cnt         <= kill ? '0 : cnt + (AW+1)'(push) - (AW+1)'(pop);
      wr_ptr      <= wr_ptr + AW'(push);
      rd_ptr      <= kill ? wr_ptr : rd_ptr + AW'(pop);
      phase       <= !kill && (phase ^ wr);
      bus.tile_we <= wr;
      if (wr) begin
        bus.tile_waddr <= wa;
        bus.tile_wdata <= phase ? head[31:16] : head[15:0];
        wa             <= wa + 14'd1;
      end
      if (state == IDLE && start) begin
        wa           <= dst_addr;
        bus.ram_addr <= src_addr;
        remain       <= len;
        bus.ram_req  <= len != '0;
      end else begin
        bus.ram_req <= (bus.ram_req && !ack) || issue;
        if (ack) begin
          bus.ram_addr <= bus.ram_addr + 23'd1;
          remain       <= remain - 13'd1;
        end
      end
    end
`ifdef VDP_DMA_ABORT_EN
  always_ff @(posedge clk_draw or negedge rst_draw_n)
    if (!rst_draw_n) aborting <= 1'b0;
    else aborting <= state_nx == FLUSH && kill;
`endif
endmodule

// File: tb/tb_tile_dma.sv
// tb_tile_dma: directed copies; stimulus queues expected reads and writes, monitors pop and compare.
module tb_tile_dma;
  typedef struct {int due; logic [31:0] q;} ret_t;
  logic clk = 0, rst_n = 0, start = 0;
  logic [22:0] src = 0;
  logic [13:0] dst = 0;
  logic [12:0] len = 0;
  logic busy, done;
`ifdef VDP_DMA_ABORT_EN
  logic abort = 0;
`endif
  tile_dma_if bus();
  tile_dma #(.FIFO_DEPTH(4)) dut (
    .clk_draw(clk),
    .rst_draw_n(rst_n),
    .start(start),
    .src_addr(src),
    .dst_addr(dst),
    .len(len),
    .busy(busy),
    .done(done),
`ifdef VDP_DMA_ABORT_EN
    .abort(abort),
`endif
    .bus(bus)
  );
  int checks = 0, errors = 0, cyc = 0, lat = 3, inflight = 0, max_inflight = 0;
  int acks = 0, done_cnt = 0, last_we = -10, first_we = -1, first_valid = -1, n0 = 0, a0 = 0;
  bit ack_en = 1, zero_len = 0;
  ret_t ret[$];
  logic [22:0] raq[$];
  logic [29:0] wq[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] word(input logic [22:0] a);
    return a == 23'h10 ? 32'hBEEF1234 : {~a[15:0], a[15:0]};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // SDRAM model: acks every request at once, returns data lat cycles later
  always @(negedge clk) begin
    bus.ram_ack = 0;
    bus.ram_valid = 0;
    bus.ram_q = '0;
    if (rst_n) begin
      if (ret.size() > 0 && ret[0].due <= cyc) begin
        bus.ram_valid = 1;
        bus.ram_q = ret[0].q;
        void'(ret.pop_front());
        inflight--;
        if (first_valid < 0) first_valid = cyc;
      end
      if (bus.ram_req && ack_en) begin
        bus.ram_ack = 1;
        acks++;
        inflight++;
        if (inflight > max_inflight) max_inflight = inflight;
        ret.push_back('{cyc + lat, word(bus.ram_addr)});
        if (raq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL read_addr: unexpected read at %0h", bus.ram_addr);
        end else chk("read_addr", bus.ram_addr, raq.pop_front());
      end
    end
  end

  // write and done monitor
  always @(negedge clk) if (rst_n) begin
    if (bus.tile_we) begin
      if (first_we < 0) first_we = cyc;
      last_we = cyc;
      if (wq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL tile_write: unexpected %0h at %0h", bus.tile_wdata, bus.tile_waddr);
      end else chk("tile_write", {bus.tile_waddr, bus.tile_wdata}, wq.pop_front());
    end
    if (done) begin
      done_cnt++;
      chk("done_busy", busy, zero_len);
      if (first_we >= 0) chk("done_after_write", cyc - last_we, 1);
    end
  end

  task automatic expect_copy(input logic [22:0] s, input logic [13:0] d, input int l);
    for (int k = 0; k < l; k++) begin
      logic [22:0] a;
      logic [31:0] w;
      a = s + 23'(k);
      w = word(a);
      raq.push_back(a);
      wq.push_back({d + 14'(2 * k), w[15:0]});
      wq.push_back({d + 14'(2 * k + 1), w[31:16]});
    end
  endtask

  task automatic go(input logic [22:0] s, input logic [13:0] d, input logic [12:0] l);
    first_we = -1;
    first_valid = -1;
    max_inflight = 0;
    n0 = done_cnt;
    a0 = acks;
    @(negedge clk);
    start = 1;
    src = s;
    dst = d;
    len = l;
    @(negedge clk);
    start = 0;
    chk("start_busy", busy, 1);
    chk("start_req", bus.ram_req, l != 0);
    chk("start_done", done, l == 0);
  endtask

  task automatic wait_done();
    int t = 0;
    while (done_cnt == n0 && t < 3000) begin
      @(negedge clk);
      t++;
    end
    if (done_cnt == n0) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: no done after %0d cycles", t);
    end
    repeat (3) @(negedge clk);
    chk("done_once", done_cnt - n0, 1);
    chk("idle_busy", busy, 0);
    chk("writes_left", wq.size(), 0);
    chk("reads_left", raq.size(), 0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_outputs", {busy, done, bus.ram_req, bus.ram_addr, bus.tile_we, bus.tile_waddr, bus.tile_wdata}, 0);
    rst_n = 1;
    @(negedge clk);
    // single word, halves in order
    lat = 3;
    raq.push_back(23'h10);
    wq.push_back({14'h0100, 16'h1234});
    wq.push_back({14'h0101, 16'hBEEF});
    go(23'h10, 14'h100, 1);
    wait_done();
    chk("we_after_valid", first_we - first_valid, 1);
    // eight words, limited reads in flight
    expect_copy(23'h1000, 14'h0200, 8);
    go(23'h1000, 14'h0200, 8);
    wait_done();
    chk("max_inflight_le4", max_inflight <= 4, 1);
    // tile address wraps
    raq.push_back(23'h20);
    wq.push_back({14'h3FFF, 16'h0020});
    wq.push_back({14'h0000, 16'hFFDF});
    go(23'h20, 14'h3FFF, 1);
    wait_done();
    // SDRAM address wraps
    lat = 1;
    raq.push_back(23'h7FFFFF);
    raq.push_back(23'h000000);
    wq.push_back({14'h0010, 16'hFFFF});
    wq.push_back({14'h0011, 16'h0000});
    wq.push_back({14'h0012, 16'h0000});
    wq.push_back({14'h0013, 16'hFFFF});
    go(23'h7FFFFF, 14'h10, 2);
    wait_done();
    // zero length
    zero_len = 1;
    go(23'h50, 14'h50, 0);
    wait_done();
    zero_len = 0;
    // start while busy is ignored
    lat = 2;
    expect_copy(23'h300, 14'h80, 4);
    go(23'h300, 14'h80, 4);
    @(negedge clk);
    start = 1;
    src = 23'h40;
    dst = 14'h3000;
    len = 13'd9;
    @(negedge clk);
    start = 0;
    wait_done();
    // asynchronous reset with two reads outstanding
    lat = 10;
    raq.push_back(23'h500);
    raq.push_back(23'h501);
    go(23'h500, 14'h600, 4);
    for (int t = 0; t < 100 && acks - a0 < 2; t++) @(posedge clk);
    chk("reset_acks", acks - a0, 2);
    #1 rst_n = 0;
    #1 chk("midreset_outputs", {busy, done, bus.ram_req, bus.ram_addr, bus.tile_we, bus.tile_waddr, bus.tile_wdata}, 0);
    ret.delete();
    raq.delete();
    wq.delete();
    inflight = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
    lat = 3;
    expect_copy(23'h700, 14'h20, 2);
    go(23'h700, 14'h20, 2);
    wait_done();
`ifdef VDP_DMA_ABORT_EN
    // abort after two acks: the held third request completes, nothing is written
    raq.push_back(23'h900);
    raq.push_back(23'h901);
    raq.push_back(23'h902);
    go(23'h900, 14'h100, 6);
    for (int t = 0; t < 100 && acks - a0 < 2; t++) @(posedge clk);
    #1 ack_en = 0;
    abort = 1;
    @(posedge clk);
    #1 abort = 0;
    repeat (3) @(posedge clk);
    #1 ack_en = 1;
    wait_done();
    chk("abort_acks", acks - a0, 3);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
